fp_wb_stage: RTL and testbench
==============================

Name: fp_wb_stage

Overview:
Writeback stage directly downstream of the FP sign-inject/min-max unit (short, fixed latency) and the FMA pipe (long, fixed latency).
- Tracks in-flight ops with valid/rd/wflags delay lines that match each unit's latency.
- Reserves the single FP regfile write port at issue time and refuses colliding issues.
- Muxes the finished 33-bit recoded result onto the regfile write port and accumulates fflags.

Parameters:
SHORT_LAT, 2, cycles from issue to result for the short unit (min 1)
LONG_LAT, 4, cycles from issue to result for the long unit (must be > SHORT_LAT)
FLEN, 33, recoded FP width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
issue_valid  in  1  op issued this cycle
issue_unit  in  1  0 = short unit, 1 = long unit
issue_rd  in  5  destination FP register
issue_wflags  in  1  op updates fflags
issue_ready  out  1  issue is accepted this cycle (comb)
flush  in  1  kill all in-flight ops
short_data  in  FLEN  short-unit result
short_exc  in  5  short-unit exception flags
long_data  in  FLEN  long-unit result
long_exc  in  5  long-unit exception flags
wb_valid  out  1  regfile write enable
wb_rd  out  5  regfile write address
wb_data  out  FLEN  regfile write data
fflags_clr  in  1  clear accumulated flags (CSR write)
fflags_acc  out  5  accumulated exception flags
busy  out  1  any op in flight

Behaviour:
- Reservation vector R[LONG_LAT-1:0]: each cycle R <= (R >> 1) | accepted-issue bit at position (lat-1).
- issue_ready = !R[lat] for the requested unit's latency; an out-of-range bit reads as 0. Depends only on issue_unit and R.
- An issue is accepted iff issue_valid & issue_ready.
- A refused issue is dropped. Upstream must hold and retry.
- Short pipe: SHORT_LAT stages of {v, rd, wflags}. Long pipe: LONG_LAT stages. Both shift every cycle; stage 0 loads the accepted issue.
- An op issued in cycle 0 writes back in cycle lat: short in cycle 2, long in cycle 4.
- Writeback is combinational from the last pipe stages:
  - wb_valid = short_last.v | long_last.v
  - wb_rd and wb_data are taken from whichever last stage is valid.
  - If both are valid (impossible by construction), long wins and the short op is discarded.
- fflags_acc <= (fflags_clr ? 0 : fflags_acc) | (wb_valid & last.wflags ? exc : 0). A simultaneous clr and new flags leaves exactly the new flags.
- flush clears R and every pipe valid bit next cycle.
  - An issue in the flush cycle is refused (issue_ready = 0).
  - fflags_acc is unchanged.
  - A writeback already presenting in the flush cycle still completes.
- busy = |R.
- Reset (reset == 0 at a clock edge), including mid-operation:
  - R, all pipe valid bits and fflags_acc are set to 0.
  - wb_valid = 0, issue_ready = 1, busy = 0.
  - rd/data pipe fields are not reset.

Optional Feature:
Macro FP_WB_IEEE_EN.
- Defined: adds output wb_ieee[31:0], a combinational recoded-to-IEEE single conversion of wb_data.
  - Field split: s = bit32, r = bits31:23, f = bits22:0.
  - r[8:6] = 000: zero, exp 0, frac 0.
  - r[8:6] = 110: inf, exp 0xFF, frac 0.
  - r[8:6] = 111: NaN, exp 0xFF, frac f.
  - r >= 0x82: normal, exp = r - 0x81, frac f.
  - Otherwise: subnormal, exp 0, frac = ({1,f} >> (0x82 - r))[22:0].
- Undefined: the port and its logic are absent.

Decomposition:
- Shared FPU package: FLEN, flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0), recoded-exponent constants (0x81, 0x82, class codes 000/110/111), unit-select encoding.
- Sub-module: fp_lat_pipe, a parameterised {v, rd, wflags} delay line with flush, instantiated once per unit.
- The IEEE converter is a function in the package.

Test Plan:
- Short issue cycle 0, rd = 3, short_data = 33'h080000000 in cycle 2 -> cycle 2: wb_valid = 1, wb_rd = 3, wb_data = 33'h080000000; wb_ieee = 0x3F800000 when FP_WB_IEEE_EN is defined.
- Long issue cycle 0, short issue attempted cycle 2 -> issue_ready = 0 in cycle 2; retry cycle 3 accepted; writebacks in cycles 4 and 5.
- wflags = 1 op writes back with exc = 5'h10 -> fflags_acc = 5'h10; next writeback exc = 5'h01 with fflags_clr = 1 same cycle -> fflags_acc = 5'h01.
- Long issue cycle 0, flush cycle 1 -> no wb_valid in cycle 4; busy = 0 from cycle 2; fflags_acc unchanged.
- reset = 0 in cycle 1 with two ops in flight -> wb_valid = 0 thereafter, fflags_acc = 0, issue_ready = 1 for both units.
- FP_WB_IEEE_EN defined, wb_data = 33'h0E0400000 -> wb_ieee = 0x7FC00000; recoded r = 0x081, f = 0 -> wb_ieee = 0x00400000.

Source files
------------

// File: rtl/fp_wb_stage_pkg.sv
// Shared FPU definitions for the FP writeback stage: widths, flag positions,
// recoded-exponent constants, unit encoding and the recoded-to-IEEE helper.
package fp_wb_stage_pkg;

  localparam int FLEN = 33;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [8:0] REC_EXP_OFS      = 9'h081;
  localparam logic [8:0] REC_EXP_MIN_NORM = 9'h082;
  localparam logic [2:0] REC_CLS_ZERO     = 3'b000;
  localparam logic [2:0] REC_CLS_INF      = 3'b110;
  localparam logic [2:0] REC_CLS_NAN      = 3'b111;

  typedef enum logic {
    UNIT_SHORT = 1'b0,
    UNIT_LONG  = 1'b1
  } fp_unit_e;

  function automatic logic [31:0] rec_to_ieee(input logic [32:0] rec);
    logic        s;
    logic [8:0]  r;
    logic [22:0] f;
    logic [7:0]  e;
    logic [22:0] m;
    logic [23:0] sig;
    logic [8:0]  sh;
    s   = rec[32];
    r   = rec[31:23];
    f   = rec[22:0];
    sig = {1'b1, f};
    sh  = REC_EXP_MIN_NORM - r;
    e   = 8'h00;
    m   = 23'h0;
    if (r[8:6] == REC_CLS_ZERO) begin
      e = 8'h00;
      m = 23'h0;
    end else if (r[8:6] == REC_CLS_INF) begin
      e = 8'hFF;
      m = 23'h0;
    end else if (r[8:6] == REC_CLS_NAN) begin
      e = 8'hFF;
      m = f;
    end else if (r >= REC_EXP_MIN_NORM) begin
      e = 8'(r - REC_EXP_OFS);
      m = f;
    end else begin
      // Subnormal: restore the hidden one and denormalise into the fraction.
      m = 23'(sig >> sh);
    end
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_wb_stage_lat_pipe.sv
// Fixed-latency {valid, rd, wflags} delay line; valid bits clear on reset or flush,
// payload fields are plain shift registers.
module fp_lat_pipe #(
  parameter int LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_v,
  input  logic [4:0] in_rd,
  input  logic       in_wflags,
  output logic       out_v,
  output logic [4:0] out_rd,
  output logic       out_wflags
);

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] wf_q;
  logic [4:0]     rd_q [LAT];

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_v;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    rd_q[0] <= in_rd;
    wf_q[0] <= in_wflags;
    for (int i = 1; i < LAT; i++) begin
      rd_q[i] <= rd_q[i-1];
      wf_q[i] <= wf_q[i-1];
    end
  end

  assign out_v      = v_q[LAT-1];
  assign out_rd     = rd_q[LAT-1];
  assign out_wflags = wf_q[LAT-1];

endmodule

// File: rtl/fp_wb_stage.sv
// FP writeback stage: reserves the single regfile write port at issue, tracks
// in-flight short/long ops and accumulates fflags. FP_WB_IEEE_EN adds wb_ieee.
module fp_wb_stage #(
  parameter int SHORT_LAT = 2,
  parameter int LONG_LAT  = 4,
  parameter int FLEN      = fp_wb_stage_pkg::FLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_unit,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wflags,
  output logic            issue_ready,
  input  logic            flush,
  input  logic [FLEN-1:0] short_data,
  input  logic [4:0]      short_exc,
  input  logic [FLEN-1:0] long_data,
  input  logic [4:0]      long_exc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [FLEN-1:0] wb_data,
  input  logic            fflags_clr,
  output logic [4:0]      fflags_acc,
  output logic            busy
`ifdef FP_WB_IEEE_EN
  ,
  output logic [31:0]     wb_ieee
`endif
);

  import fp_wb_stage_pkg::*;

  logic [LONG_LAT-1:0] r_q, r_d;
  logic [4:0]          fflags_q, fflags_d;
  logic                accept;
  logic                s_v, s_wf, l_v, l_wf;
  logic [4:0]          s_rd, l_rd;
  logic                sel_wf;
  logic [4:0]          sel_exc;

  // R[k] set means the write port is taken k cycles from now; the long
  // latency indexes past the top of R, so the long unit never sees a clash.
  always_comb begin
    issue_ready = 1'b0;
    if (!flush) begin
      issue_ready = (issue_unit == UNIT_SHORT) ? !r_q[SHORT_LAT] : 1'b1;
    end
  end

  assign accept = issue_valid & issue_ready;

  always_comb begin
    r_d = r_q >> 1;
    if (accept) begin
      if (issue_unit == UNIT_SHORT) begin
        r_d[SHORT_LAT-1] = 1'b1;
      end else begin
        r_d[LONG_LAT-1] = 1'b1;
      end
    end
    if (flush) begin
      r_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q      <= '0;
      fflags_q <= '0;
    end else begin
      r_q      <= r_d;
      fflags_q <= fflags_d;
    end
  end

  fp_lat_pipe #(.LAT(SHORT_LAT)) u_short_pipe (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_v       (accept & (issue_unit == UNIT_SHORT)),
    .in_rd      (issue_rd),
    .in_wflags  (issue_wflags),
    .out_v      (s_v),
    .out_rd     (s_rd),
    .out_wflags (s_wf)
  );

  fp_lat_pipe #(.LAT(LONG_LAT)) u_long_pipe (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_v       (accept & (issue_unit == UNIT_LONG)),
    .in_rd      (issue_rd),
    .in_wflags  (issue_wflags),
    .out_v      (l_v),
    .out_rd     (l_rd),
    .out_wflags (l_wf)
  );

  // Long wins a (theoretically impossible) double completion.
  assign wb_valid = s_v | l_v;
  assign wb_rd    = l_v ? l_rd      : s_rd;
  assign wb_data  = l_v ? long_data : short_data;
  assign sel_wf   = l_v ? l_wf      : s_wf;
  assign sel_exc  = l_v ? long_exc  : short_exc;

  always_comb begin
    fflags_d = fflags_clr ? 5'h00 : fflags_q;
    if (wb_valid && sel_wf) begin
      fflags_d = fflags_d | sel_exc;
    end
  end

  assign fflags_acc = fflags_q;
  assign busy       = |r_q;

`ifdef FP_WB_IEEE_EN
  assign wb_ieee = rec_to_ieee(wb_data);
`endif

endmodule

// File: tb/tb_fp_wb_stage.sv
// Scoreboard bench for fp_wb_stage: stimulus pushes expected writebacks,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_fp_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_unit, issue_wflags, issue_ready;
  logic [4:0]  issue_rd;
  logic        flush, fflags_clr;
  logic [32:0] short_data, long_data, wb_data;
  logic [4:0]  short_exc, long_exc, wb_rd, fflags_acc;
  logic        wb_valid, busy;
`ifdef FP_WB_IEEE_EN
  logic [31:0] wb_ieee;
`endif

  always #5 clock = ~clock;

  fp_wb_stage dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_unit   (issue_unit),
    .issue_rd     (issue_rd),
    .issue_wflags (issue_wflags),
    .issue_ready  (issue_ready),
    .flush        (flush),
    .short_data   (short_data),
    .short_exc    (short_exc),
    .long_data    (long_data),
    .long_exc     (long_exc),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .fflags_clr   (fflags_clr),
    .fflags_acc   (fflags_acc),
    .busy         (busy)
`ifdef FP_WB_IEEE_EN
    ,
    .wb_ieee      (wb_ieee)
`endif
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [32:0] data;
    logic [31:0] ieee;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end else begin
      $display("ok   %s @cycle %0d: %h", name, cyc, act);
    end
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (wb_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_wb @cycle %0d: got rd %0d data %h, expected no writeback",
                 cyc, wb_rd, wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(e.cyc));
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
`ifdef FP_WB_IEEE_EN
        chk("wb_ieee", 64'(wb_ieee), 64'(e.ieee));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    flush       = 1'b0;
    fflags_clr  = 1'b0;
    short_exc   = 5'h00;
    long_exc    = 5'h00;
  endtask

  task automatic issue_np(input logic unit, input logic [4:0] rd, input logic wf);
    issue_valid  = 1'b1;
    issue_unit   = unit;
    issue_rd     = rd;
    issue_wflags = wf;
    #1;
    chk("issue_ready", 64'(issue_ready), 64'd1);
  endtask

  task automatic issue(input logic unit, input logic [4:0] rd, input logic wf,
                       input logic [32:0] data, input logic [31:0] ieee);
    exp_t e;
    issue_np(unit, rd, wf);
    e.cyc  = cyc + (unit ? 4 : 2);
    e.rd   = rd;
    e.data = data;
    e.ieee = ieee;
    sb.push_back(e);
  endtask

  initial begin
    reset        = 1'b0;
    issue_valid  = 1'b0;
    issue_unit   = 1'b0;
    issue_rd     = 5'd0;
    issue_wflags = 1'b0;
    flush        = 1'b0;
    fflags_clr   = 1'b0;
    short_data   = 33'h0;
    long_data    = 33'h0;
    short_exc    = 5'h00;
    long_exc     = 5'h00;
    repeat (3) tick();

    // reset state
    issue_unit = 1'b0; #1;
    chk("rst_ready_short", 64'(issue_ready), 64'd1);
    issue_unit = 1'b1; #1;
    chk("rst_ready_long", 64'(issue_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fflags", 64'(fflags_acc), 64'd0);
    reset = 1'b1;
    tick();

    // short op, 1.0
    issue(1'b0, 5'd3, 1'b0, 33'h0_8000_0000, 32'h3F80_0000);
    tick();
    chk("busy_short", 64'(busy), 64'd1);
    tick();
    short_data = 33'h0_8000_0000;
    tick();
    tick();

    // long op then colliding short, retried one cycle later
    issue(1'b1, 5'd7, 1'b0, 33'h1_8000_0000, 32'hBF80_0000);
    tick();
    tick();
    issue_valid = 1'b1; issue_unit = 1'b0; issue_rd = 5'd9; issue_wflags = 1'b0; #1;
    chk("ready_collide", 64'(issue_ready), 64'd0);
    tick();
    issue(1'b0, 5'd9, 1'b0, 33'h0_8080_0000, 32'h4000_0000);
    tick();
    long_data = 33'h1_8000_0000;
    long_exc  = 5'h04;
    tick();
    chk("fflags_nowflags", 64'(fflags_acc), 64'd0);
    short_data = 33'h0_8080_0000;
    tick();
    tick();

    // fflags accumulate, then clear plus new flags in the same cycle
    issue(1'b0, 5'd1, 1'b1, 33'h0_E040_0000, 32'h7FC0_0000);
    tick();
    issue(1'b0, 5'd2, 1'b1, 33'h0_4080_0000, 32'h0040_0000);
    tick();
    short_data = 33'h0_E040_0000;
    short_exc  = 5'h10;
    tick();
    chk("fflags_acc_10", 64'(fflags_acc), 64'h10);
    short_data = 33'h0_4080_0000;
    short_exc  = 5'h01;
    fflags_clr = 1'b1;
    tick();
    chk("fflags_clr_new", 64'(fflags_acc), 64'h01);
    tick();

    // flush kills a long op in flight
    issue_np(1'b1, 5'd4, 1'b1);
    tick();
    chk("busy_pre_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    issue_valid = 1'b1; issue_unit = 1'b0; issue_rd = 5'd8; #1;
    chk("flush_ready_short", 64'(issue_ready), 64'd0);
    issue_unit = 1'b1; #1;
    chk("flush_ready_long", 64'(issue_ready), 64'd0);
    tick();
    chk("busy_post_flush", 64'(busy), 64'd0);
    tick();
    tick();
    long_exc = 5'h1F;
    tick();
    chk("fflags_after_flush", 64'(fflags_acc), 64'h01);
    tick();

    // reset with two ops in flight
    issue_np(1'b1, 5'd5, 1'b1);
    tick();
    issue_np(1'b0, 5'd6, 1'b1);
    tick();
    chk("busy_pre_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_fflags", 64'(fflags_acc), 64'd0);
    chk("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
    issue_unit = 1'b0; #1;
    chk("mid_rst_ready_short", 64'(issue_ready), 64'd1);
    issue_unit = 1'b1; #1;
    chk("mid_rst_ready_long", 64'(issue_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      short_exc = 5'h1F;
      long_exc  = 5'h1F;
      tick();
    end
    chk("mid_rst_fflags_end", 64'(fflags_acc), 64'd0);

    tick();
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
